// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// The port mux and scoreboard live in the top; the deferred result buffer is wb_fifo.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  // Pipeline writeback selector encodings, shared with the writeback stage
  localparam logic [1:0] WB_SEL_PC4 = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  localparam logic [1:0] WB_SEL_MEM = 2'b10;

  typedef enum logic {
    SRC_PIPE = 1'b0,
    SRC_LSU  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding deferred long-latency results ({rd, data}).
// Pointers wrap at DEPTH. A push into a full FIFO is legal only when a pop happens in the same cycle.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// long-latency results, and scoreboards outstanding long-latency destinations.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN      = wb_pkg::XLEN,
  parameter int NREG      = wb_pkg::NREG,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  reg_idx_t        pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            lsu_valid,
  input  reg_idx_t        lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            issue_valid,
  input  logic            issue_long,
  input  reg_idx_t        issue_rd,
  input  reg_idx_t        issue_rs1,
  input  reg_idx_t        issue_rs2,
  output logic            issue_stall,
  output logic            rf_we,
  output reg_idx_t        rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int IW = $clog2(NREG);
  localparam int EW = XLEN + 5;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [EW-1:0]   fifo_head;
  reg_idx_t        head_rd;
  logic [XLEN-1:0] head_data;
  logic            lsu_acc;

  logic            wr_valid;
  reg_idx_t        wr_rd;
  logic [XLEN-1:0] wr_data;
  wb_src_e         wr_src;
  wb_src_e         rf_src;

  logic [NREG-1:0] pending;
  logic            issue_set;

  assign {head_rd, head_data} = fifo_head;

  // Queued results drain only when the pipeline leaves the port idle; never bypassed.
  assign fifo_pop  = !pipe_valid && !fifo_empty;
  assign lsu_ready = !rst && (!fifo_full || fifo_pop);
  assign lsu_acc   = lsu_valid && lsu_ready;
  assign fifo_push = lsu_acc && (pipe_valid || !fifo_empty);

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({lsu_rd, lsu_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    wr_valid = 1'b0;
    wr_rd    = '0;
    wr_data  = '0;
    wr_src   = SRC_PIPE;
    if (pipe_valid) begin
      wr_valid = 1'b1;
      wr_rd    = pipe_rd;
      wr_data  = pipe_data;
    end else if (!fifo_empty) begin
      wr_valid = 1'b1;
      wr_rd    = head_rd;
      wr_data  = head_data;
      wr_src   = SRC_LSU;
    end else if (lsu_acc) begin
      wr_valid = 1'b1;
      wr_rd    = lsu_rd;
      wr_data  = lsu_data;
      wr_src   = SRC_LSU;
    end
  end

  // x0 writes are consumed here so they never reach the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_src   <= SRC_PIPE;
    end else begin
      rf_we <= wr_valid && (wr_rd != '0);
      if (wr_valid && (wr_rd != '0)) begin
        rf_waddr <= wr_rd;
        rf_wdata <= wr_data;
        rf_src   <= wr_src;
      end
    end
  end

  function automatic logic is_pending(input logic [NREG-1:0] p, input reg_idx_t idx);
    return (idx != '0) && p[idx[IW-1:0]];
  endfunction

  assign issue_stall = !rst && issue_valid &&
                       (is_pending(pending, issue_rs1) ||
                        is_pending(pending, issue_rs2) ||
                        is_pending(pending, issue_rd));

  assign issue_set = issue_valid && issue_long && !issue_stall && (issue_rd != '0);

  // Clear is driven by the registered write, so a stall drops one cycle after rf_we
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (rf_we && (rf_src == SRC_LSU)) pending[rf_waddr[IW-1:0]] <= 1'b0;
      if (issue_set) pending[issue_rd[IW-1:0]] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the port and scoreboard.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN      (32),
    .NREG      (32),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_valid  (pipe_valid),
    .pipe_rd     (pipe_rd),
    .pipe_data   (pipe_data),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .issue_valid (issue_valid),
    .issue_long  (issue_long),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  // Reference model: queued lsu results, pending registers, expected registered write
  res_t        q[$];
  bit          pend[32];
  bit          m_we;
  bit          m_lsu;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int   n_checks = 0;
  int   n_errors = 0;
  logic obs_stall;
  logic obs_ready;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r,
                      input bit pv, input logic [4:0] prd, input logic [31:0] pdat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input bit iv, input bit il, input logic [4:0] ird,
                      input logic [4:0] irs1, input logic [4:0] irs2);
    bit          e_ready, e_stall, acc, w_v, w_lsu;
    logic [4:0]  w_rd;
    logic [31:0] w_d;
    res_t        h;
    @(negedge clk);
    rst = r; pipe_valid = pv; pipe_rd = prd; pipe_data = pdat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    issue_valid = iv; issue_long = il; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
    #1;
    e_ready = !r && ((q.size() < DEPTH) || (!pv && q.size() > 0));
    e_stall = !r && iv && ((irs1 != 5'd0 && pend[irs1]) ||
                           (irs2 != 5'd0 && pend[irs2]) ||
                           (ird  != 5'd0 && pend[ird]));
    obs_ready = lsu_ready;
    obs_stall = issue_stall;
    check_val("lsu_ready", 64'(lsu_ready), 64'(e_ready));
    check_val("issue_stall", 64'(issue_stall), 64'(e_stall));
    acc = lv && e_ready;
    if (r) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_we = 1'b0; m_lsu = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (m_we && m_lsu) pend[m_addr] = 1'b0;
      if (iv && il && !e_stall && ird != 5'd0) pend[ird] = 1'b1;
      w_v = 1'b0; w_lsu = 1'b0; w_rd = '0; w_d = '0;
      if (pv) begin
        w_v = 1'b1; w_rd = prd; w_d = pdat;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        w_v = 1'b1; w_lsu = 1'b1; w_rd = h.rd; w_d = h.data;
      end else if (acc) begin
        w_v = 1'b1; w_lsu = 1'b1; w_rd = lrd; w_d = ldat;
        acc = 1'b0;
      end
      if (acc) begin
        h.rd = lrd; h.data = ldat;
        q.push_back(h);
      end
      m_we = w_v && (w_rd != 5'd0);
      m_lsu = w_lsu; m_addr = w_rd; m_data = w_d;
    end
    @(posedge clk);
    #1;
    check_val("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we || r) begin
      check_val("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      check_val("rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    foreach (pend[i]) pend[i] = 1'b0;
    m_we = 1'b0; m_lsu = 1'b0; m_addr = '0; m_data = '0;

    // Reset held two cycles with a result offered
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h55, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h55, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("rst_ready", 64'(obs_ready), 64'd0);
    check_val("rst_we", 64'(rf_we), 64'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2);
    check_val("post_rst_ready", 64'(obs_ready), 64'd1);
    check_val("post_rst_stall", 64'(obs_stall), 64'd0);

    // Pipeline write alone
    step(1'b0, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("pipe_we", 64'(rf_we), 64'd1);
    check_val("pipe_addr", 64'(rf_waddr), 64'd5);
    check_val("pipe_data", 64'(rf_wdata), 64'h1234);

    // Collision: pipe first, lsu one cycle later
    step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("coll_ready", 64'(obs_ready), 64'd1);
    check_val("coll_first", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd3, 32'hA}));
    idle();
    check_val("coll_second", 64'({rf_we, rf_waddr, rf_wdata}), 64'({1'b1, 5'd7, 32'hB}));

    // Scoreboard RAW/WAW and stall release timing
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    check_val("sb_issue", 64'(obs_stall), 64'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 5'd9, 5'd0);
    check_val("sb_raw", 64'(obs_stall), 64'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    check_val("sb_waw", 64'(obs_stall), 64'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 5'd10, 5'd9, 5'd0);
    check_val("sb_lsu_cycle", 64'(obs_stall), 64'd1);
    check_val("sb_write", 64'({rf_we, rf_waddr}), 64'({1'b1, 5'd9}));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 5'd9, 5'd0);
    check_val("sb_we_cycle", 64'(obs_stall), 64'd1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd10, 5'd9, 5'd0);
    check_val("sb_release", 64'(obs_stall), 64'd0);

    // Full FIFO behind continuous pipe writes, then in-order drain
    step(1'b0, 1'b1, 5'd20, 32'h1, 1'b1, 5'd1, 32'h111, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd21, 32'h2, 1'b1, 5'd2, 32'h222, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("full_second_ready", 64'(obs_ready), 64'd1);
    step(1'b0, 1'b1, 5'd22, 32'h3, 1'b1, 5'd3, 32'h333, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("full_third_ready", 64'(obs_ready), 64'd0);
    step(1'b0, 1'b1, 5'd23, 32'h4, 1'b1, 5'd3, 32'h333, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("full_held_ready", 64'(obs_ready), 64'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h333, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("full_poppush_ready", 64'(obs_ready), 64'd1);
    check_val("drain_x1", 64'({rf_waddr, rf_wdata}), 64'({5'd1, 32'h111}));
    idle();
    check_val("drain_x2", 64'({rf_waddr, rf_wdata}), 64'({5'd2, 32'h222}));
    idle();
    check_val("drain_x3", 64'({rf_waddr, rf_wdata}), 64'({5'd3, 32'h333}));

    // x0 result is accepted but never written
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check_val("x0_ready", 64'(obs_ready), 64'd1);
    check_val("x0_we", 64'(rf_we), 64'd0);

    // Reset while entries are queued discards them
    step(1'b0, 1'b1, 5'd6, 32'h6, 1'b1, 5'd8, 32'h8, 1'b1, 1'b1, 5'd12, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd12, 5'd12, 5'd0);
    check_val("midrst_we", 64'(rf_we), 64'd0);
    check_val("midrst_stall", 64'(obs_stall), 64'd0);

    // Random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
